// File: rtl/fan_speed_ramp.sv
// Fan speed sequencer feeding the PWM generator's duty input.
// Converts speed/off button pulses into a 4-level setting and slews the
// duty toward the level target, with a full-duty kick when spinning up
// from standstill.
module fan_speed_ramp #(
  parameter int unsigned N           = 12,
  parameter int unsigned RAMP_DIV    = 12500,
  parameter int unsigned STEP        = 16,
  parameter int unsigned KICK_CYCLES = 25000000,
  parameter int unsigned DUTY_LOW    = 1365,
  parameter int unsigned DUTY_MID    = 2730,
  parameter int unsigned DUTY_HIGH   = 4095
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         btn_speed,
  input  logic         btn_off,
  output logic [N-1:0] duty,
  output logic [1:0]   level,
  output logic         busy
);

  localparam int unsigned KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [N-1:0]  DUTY_MAX  = '1;
  localparam logic [N-1:0]  STEP_N    = N'(STEP);
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StKick = 2'd1;
  localparam logic [1:0] StRamp = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  duty_q, duty_d;
  logic [1:0]    level_q, level_d;
  logic [KW-1:0] kick_q, kick_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q;

  logic          level_chg;
  logic [N-1:0]  target;
  logic [N-1:0]  step_val;
  logic [N:0]    duty_ext, tgt_ext, step_ext, up_sum, dn_lim;

  // Level register next state: off beats speed when both arrive together.
  always_comb begin
    level_d = level_q;
    if (btn_off) begin
      level_d = 2'd0;
    end else if (btn_speed) begin
      level_d = level_q + 2'd1;
    end
  end

  assign level_chg = (level_d != level_q);

  // Target follows the new level so the FSM reacts on the same edge.
  always_comb begin
    target = '0;
    case (level_d)
      2'd1:    target = N'(DUTY_LOW);
      2'd2:    target = N'(DUTY_MID);
      2'd3:    target = N'(DUTY_HIGH);
      default: target = '0;
    endcase
  end

  // One bounded slew step toward the target, computed in N+1 bits so the
  // intermediate never wraps.
  always_comb begin
    duty_ext = {1'b0, duty_q};
    tgt_ext  = {1'b0, target};
    step_ext = {1'b0, STEP_N};
    up_sum   = duty_ext + step_ext;
    dn_lim   = tgt_ext + step_ext;
    step_val = target;
    if (duty_q < target) begin
      step_val = (up_sum < tgt_ext) ? up_sum[N-1:0] : target;
    end else if (duty_q > target) begin
      step_val = (duty_ext > dn_lim) ? (duty_q - STEP_N) : target;
    end
  end

  // Sequencer next-state: kick, ramp prescaler and duty update.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    kick_d  = kick_q;
    presc_d = presc_q;
    unique case (state_q)
      StIdle: begin
        duty_d  = '0;
        kick_d  = '0;
        presc_d = '0;
        if (level_chg && (target != '0)) begin
          state_d = StKick;
          duty_d  = DUTY_MAX;
        end
      end
      StKick: begin
        duty_d  = DUTY_MAX;
        presc_d = '0;
        if ((level_chg && (target == '0)) || (kick_q == KICK_LAST)) begin
          state_d = StRamp;
          kick_d  = '0;
        end else begin
          kick_d = kick_q + KW'(1);
        end
      end
      StRamp: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          duty_d  = step_val;
          if (step_val == target) begin
            state_d = (target == '0) ? StIdle : StHold;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StHold: begin
        presc_d = '0;
        if (level_chg) begin
          state_d = StRamp;
        end
      end
      default: begin
        state_d = StIdle;
        duty_d  = '0;
        kick_d  = '0;
        presc_d = '0;
      end
    endcase
  end

  // State registers; reset drops duty to zero without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      duty_q  <= '0;
      level_q <= 2'd0;
      kick_q  <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      level_q <= level_d;
      kick_q  <= kick_d;
      presc_q <= presc_d;
      busy_q  <= (state_d == StKick) || (state_d == StRamp);
    end
  end

  assign duty  = duty_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: doc/fan_speed_ramp.md
# fan_speed_ramp

Fan speed sequencer that sits directly upstream of the PWM generator and drives its `duty` input. It turns single-cycle speed and off button pulses into a 4-level speed setting: OFF, LOW, MID, HIGH. It never steps the duty to a new value in one jump. Instead it applies a full-duty kick-start when the fan spins up from standstill, then slews the duty toward the level target in bounded steps.

## Interface
- `N`, 12, duty width; must equal the PWM generator's `N`.
- `RAMP_DIV`, 12500, clocks per ramp step (100 µs at 125 MHz); ≥ 1.
- `STEP`, 16, duty change per ramp step; 1 ≤ STEP < 2^N.
- `KICK_CYCLES`, 25000000, clocks of full duty on spin-up (200 ms); ≥ 1.
- `DUTY_LOW`, 1365, target duty for LOW.
- `DUTY_MID`, 2730, target duty for MID.
- `DUTY_HIGH`, 4095, target duty for HIGH.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `btn_speed`  in  1  one-clock pulse, already debounced and synchronous; advances the level.
- `btn_off`  in  1  one-clock pulse, already debounced and synchronous; forces the level to OFF.
- `duty`  out  N  registered duty, fed to the PWM generator.
- `level`  out  2  current level: 0 = OFF, 1 = LOW, 2 = MID, 3 = HIGH.
- `busy`  out  1  high while in KICK or RAMP.

## Operation
- Level register:
  - `btn_speed` advances the level OFF→LOW→MID→HIGH→OFF, wrapping from HIGH to OFF.
  - `btn_off` sets the level to OFF.
  - If both pulses arrive in the same cycle, `btn_off` wins.
- Target duty is combinational from the level: OFF gives 0, otherwise the corresponding `DUTY_*` parameter.
- FSM states: IDLE, KICK, RAMP, HOLD.
- IDLE: duty = 0. A level change to a nonzero target moves to KICK; on that same edge duty becomes 2^N−1 and the kick counter clears.
- KICK:
  - duty is held at 2^N−1.
  - After `KICK_CYCLES` clocks in KICK, go to RAMP.
  - A level change to another nonzero target updates the target and continues the kick.
  - A change to OFF goes to RAMP immediately.
- RAMP:
  - The prescaler counts 0..RAMP_DIV−1. Each time it reaches RAMP_DIV−1 it produces one step tick and wraps to 0.
  - On a tick with duty < target: duty = min(duty+STEP, target).
  - On a tick with duty > target: duty = max(duty−STEP, target).
  - Both computations use N+1 bits, so the result never wraps past 0 or 2^N−1.
  - When duty equals the target, go to HOLD if the target is nonzero, or to IDLE if the target is 0.
  - A target change mid-ramp only redirects the slew; the prescaler keeps counting.
- HOLD: duty equals the target. A level change moves to RAMP with the prescaler cleared. Leaving HOLD never kicks, because the fan is already turning.
- `busy` = (state == KICK || state == RAMP), registered with the state.

## Timing
- Reset (`reset_n` low, asynchronous) forces:
  - state = IDLE
  - duty = 0, level = 0, busy = 0
  - prescaler and kick counter = 0
- Reset asserted mid-KICK or mid-RAMP drops duty to 0 immediately, without waiting for a clock edge.
- A button pulse sampled at edge k updates `level` at edge k. The FSM acts on the new target at the same edge k:
  - From IDLE, duty = 2^N−1 after edge k.
  - From HOLD, state = RAMP after edge k.
- Kick length: duty = 2^N−1 for exactly `KICK_CYCLES` clocks. State becomes RAMP at edge k+KICK_CYCLES.
- Ramp steps:
  - The first step lands `RAMP_DIV` clocks after entering RAMP; each later step follows `RAMP_DIV` clocks after the previous one.
  - The step that reaches the target moves the state to HOLD or IDLE on that same edge.
- The ramp from duty d to target t takes ceil(|d−t| / STEP) steps.
- `duty` is stable between steps, so the PWM generator may sample it at any time.

## Test plan
Common parameters for all scenarios: N=8, RAMP_DIV=4, STEP=16, KICK_CYCLES=8, DUTY_LOW=64, DUTY_MID=128, DUTY_HIGH=192.
- Reset: hold `reset_n` low, then release. Required: duty=0, level=0, busy=0. Assert `reset_n` low during KICK: duty=0 asynchronously.
- Spin-up: one `btn_speed` pulse from IDLE. Required:
  - level=1 and duty=255 for 8 clocks.
  - Then duty steps 239, 223, … 79, 64, one step every 4 clocks (12 steps).
  - HOLD is reached with busy=0.
- Ramp up: from HOLD at 64, one `btn_speed` pulse. Required: level=2, no kick, duty 80, 96, 112, 128 at 4-clock intervals, then HOLD.
- Wrap to OFF: from HIGH at 192, one `btn_speed` pulse. Required: level=0, duty decreasing 176 … 16, 0 (12 steps), then IDLE with busy=0.
- Simultaneous pulses: `btn_speed` and `btn_off` in the same cycle while at MID. Required: level=0 and a ramp toward 0.
- Off during kick: `btn_off` 3 clocks into KICK. Required: immediate RAMP from 255 to 0 in 16 steps, then IDLE.
